mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: drives a single-outstanding bus transfer,
// formats load data and stalls the pipeline while the transfer is in flight.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] read_data_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        fault_out,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic [1:0]  state_dbg
);

  // Bus handshake: a transfer completes in the cycle bus_req and bus_ready are
  // both high; bus_we/addr/be/wdata stay constant from bus_req rising until then,
  // and bus_rdata/bus_err are only looked at in that completing cycle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [31:0] wdata_q;

  logic [1:0]  size_c;
  logic        uns_c;
  logic        access_c;
  logic        mis_c;
  logic        start;
  logic        mis_set;
  logic        abort;
  logic        load_done;
  logic [31:0] lane;
  logic [31:0] load_data;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Unused size encodings fall back to word accesses.
  always_comb begin
    size_c = SZ_W;
    uns_c  = 1'b0;
    case (funct3_in)
      3'b000: size_c = SZ_B;
      3'b001: size_c = SZ_H;
      3'b100: begin size_c = SZ_B; uns_c = 1'b1; end
      3'b101: begin size_c = SZ_H; uns_c = 1'b1; end
      default: begin size_c = SZ_W; uns_c = 1'b0; end
    endcase
  end

  assign access_c = valid_in & (mem_read_in | mem_write_in);
  assign mis_c    = ((size_c == SZ_H) & addr_in[0]) |
                    ((size_c == SZ_W) & (addr_in[1:0] != 2'b00));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    mis_set   = 1'b0;
    abort     = 1'b0;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        if (access_c) begin
          if (mis_c) begin
            mis_set = 1'b1;
          end else begin
            start   = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus_ready) begin
          state_n = DONE;
          if (bus_err) abort = 1'b1;
          else         load_done = ~we_q;
        end else if (cnt == CNT_MAX) begin
          state_n = DONE;
          abort   = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= 8'd0;
      addr_q         <= 32'd0;
      size_q         <= 2'd0;
      uns_q          <= 1'b0;
      we_q           <= 1'b0;
      wdata_q        <= 32'd0;
      read_data_out  <= 32'd0;
      misaligned_out <= 1'b0;
      fault_out      <= 1'b0;
    end else begin
      misaligned_out <= mis_set;
      fault_out      <= abort;
      if (start) begin
        addr_q  <= addr_in;
        size_q  <= size_c;
        uns_q   <= uns_c;
        we_q    <= mem_write_in;
        wdata_q <= wdata_in;
        cnt     <= 8'd0;
      end else if ((state == BUSY) && !bus_ready) begin
        cnt <= cnt + 8'd1;
      end
      if (abort)          read_data_out <= 32'd0;
      else if (load_done) read_data_out <= load_data;
    end
  end

  // Shift the addressed byte/half down to bit 0 before extending.
  assign lane = bus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = lane;
    case (size_q)
      SZ_B:    load_data = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    load_data = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata_q;
    case (size_q)
      SZ_B: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wdata_c = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        be_c    = 4'b0011 << addr_q[1:0];
        wdata_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata_q;
      end
    endcase
  end

  // Reset clears state asynchronously, so bus_req drops with reset_n.
  assign bus_req   = (state == BUSY);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_be    = bus_req ? be_c : 4'd0;
  assign bus_wdata = bus_req ? wdata_c : 32'd0;
  assign stall_out = reset_n & (start | bus_req);
  assign state_dbg = state;

endmodule
